// File: rtl/rca_config_pkg.sv
// Shared types, sizing and packet classification for the RCA configuration path.
package rca_config_pkg;

    localparam int NUM_RCAS           = 3;
    localparam int NUM_READ_PORTS     = 5;
    localparam int NUM_WRITE_PORTS    = 2;
    localparam int NUM_GRID_MUXES     = 32;
    localparam int GRID_MUX_INPUTS    = 8;
    localparam int GRID_NUM_ROWS      = 4;
    localparam int IO_UNIT_MUX_INPUTS = 4;

    localparam int GRID_SEL_W   = $clog2(GRID_MUX_INPUTS);
    localparam int IO_SEL_W     = $clog2(IO_UNIT_MUX_INPUTS);
    localparam int RESULT_SEL_W = $clog2(GRID_NUM_ROWS);
    localparam int REG_ADDR_W   = 5;
    localparam int ID_W         = 3;

    // Address fields are wide enough to carry out-of-range requests from issue,
    // so malformed packets can be detected rather than silently aliased.
    localparam int RCA_SEL_W     = $clog2(NUM_RCAS + 1);
    localparam int PORT_SEL_W    = $clog2(NUM_READ_PORTS);
    localparam int GRID_ADDR_W   = $clog2(NUM_GRID_MUXES) + 1;
    localparam int IO_ADDR_W     = $clog2(GRID_NUM_ROWS) + 1;
    localparam int RESULT_ADDR_W = $clog2(NUM_WRITE_PORTS) + 1;
    localparam int WR_IDX_W      = $clog2(NUM_WRITE_PORTS);

    typedef logic [ID_W-1:0] id_t;

    typedef enum logic [2:0] {
        CFG_CPU_REG,
        CFG_GRID_MUX,
        CFG_IO_MUX,
        CFG_RESULT_MUX,
        CFG_INVALID
    } rca_cfg_op_t;

    // rca_sel must remain the most significant field: the FIFO exposes entry MSBs as tags.
    typedef struct packed {
        logic [RCA_SEL_W-1:0]     rca_sel;
        logic                     rca_use_instr;
        logic                     rca_cpu_reg_config;
        logic                     rca_grid_mux_config;
        logic                     rca_io_mux_config;
        logic                     rca_result_mux_config;
        logic                     rca_cpu_src_dest;
        logic [PORT_SEL_W-1:0]    rca_cpu_port_sel;
        logic [REG_ADDR_W-1:0]    rca_cpu_reg_addr;
        logic [GRID_ADDR_W-1:0]   grid_mux_addr;
        logic [GRID_SEL_W-1:0]    grid_mux_sel;
        logic [IO_ADDR_W-1:0]     io_mux_addr;
        logic [IO_SEL_W-1:0]      io_mux_sel;
        logic [RESULT_ADDR_W-1:0] rca_result_mux_addr;
        logic [RESULT_SEL_W-1:0]  rca_result_mux_sel;
    } rca_inputs_t;

    typedef struct packed {
        rca_inputs_t pkt;
        id_t         id;
    } cfg_entry_t;

    typedef struct packed {
        logic [NUM_READ_PORTS-1:0][REG_ADDR_W-1:0]  src;
        logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0] dest;
    } rca_cfg_regs_t;

    // Exactly one config flag with no use-instr, and every address in range.
    function automatic rca_cfg_op_t classify_cfg(input rca_inputs_t p);
        rca_cfg_op_t op;
        logic        bad;
        case ({p.rca_cpu_reg_config, p.rca_grid_mux_config,
               p.rca_io_mux_config, p.rca_result_mux_config})
            4'b1000: op = CFG_CPU_REG;
            4'b0100: op = CFG_GRID_MUX;
            4'b0010: op = CFG_IO_MUX;
            4'b0001: op = CFG_RESULT_MUX;
            default: op = CFG_INVALID;
        endcase
        bad = p.rca_use_instr
            || (p.rca_sel >= RCA_SEL_W'(NUM_RCAS))
            || (p.grid_mux_addr >= GRID_ADDR_W'(NUM_GRID_MUXES))
            || (p.io_mux_addr >= IO_ADDR_W'(GRID_NUM_ROWS))
            || (p.rca_result_mux_addr >= RESULT_ADDR_W'(NUM_WRITE_PORTS))
            || (p.rca_cpu_port_sel >= (p.rca_cpu_src_dest ? PORT_SEL_W'(NUM_WRITE_PORTS)
                                                           : PORT_SEL_W'(NUM_READ_PORTS)));
        if (bad) begin
            op = CFG_INVALID;
        end
        return op;
    endfunction

endpackage

// File: rtl/taiga_fifo.sv
// Small circular FIFO; entries are written in place at the write pointer.
// Also exposes per-entry valid bits and the top TAG_W bits of every entry.
module taiga_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic [DATA_WIDTH-1:0]                data_in,
    output logic [DATA_WIDTH-1:0]                data_out,
    output logic                                 valid,
    output logic                                 full,
    output logic [FIFO_DEPTH-1:0]                entry_valid,
    output logic [FIFO_DEPTH-1:0][TAG_W-1:0]     entry_tags
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] offset;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign valid    = (count_q != '0);
    assign data_out = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && valid;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Per-entry occupancy and tag view, used for per-target pending tracking.
    always_comb begin
        entry_valid = '0;
        entry_tags  = '0;
        offset      = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            offset         = PTR_W'(i) - rd_ptr_q;
            entry_valid[i] = (CNT_W'(offset) < count_q);
            entry_tags[i]  = mem_q[i][DATA_WIDTH-1 -: TAG_W];
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rca_config_unit.sv
// Buffers RCA config packets from issue, applies them to per-RCA config
// tables once the target RCA is idle, and reports completion to writeback.
module rca_config_unit
    import rca_config_pkg::*;
(
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                cfg_valid,
    output logic                                                cfg_ready,
    input  rca_inputs_t                                         cfg,
    input  id_t                                                 cfg_id,
    input  logic [NUM_RCAS-1:0]                                 rca_busy,
    output logic [NUM_RCAS-1:0]                                 cfg_pending,
    output logic                                                done_valid,
    output id_t                                                 done_id,
    output logic                                                done_err,
    output rca_cfg_regs_t [NUM_RCAS-1:0]                        rca_cfg,
    output logic [NUM_RCAS*NUM_GRID_MUXES*GRID_SEL_W-1:0]       grid_mux_sel,
    output logic [NUM_RCAS*GRID_NUM_ROWS*IO_SEL_W-1:0]          io_mux_sel,
    output logic [NUM_RCAS*NUM_WRITE_PORTS*RESULT_SEL_W-1:0]    result_mux_sel
);

    typedef enum logic {IDLE, DONE} state_t;

    localparam int FIFO_DEPTH = 2;

    state_t state_q, state_d;
    id_t    done_id_q, done_id_d;
    logic   done_err_q, done_err_d;

    rca_cfg_regs_t [NUM_RCAS-1:0] regs_q, regs_d;
    logic [NUM_RCAS-1:0][NUM_GRID_MUXES-1:0][GRID_SEL_W-1:0]    grid_q, grid_d;
    logic [NUM_RCAS-1:0][GRID_NUM_ROWS-1:0][IO_SEL_W-1:0]       io_q, io_d;
    logic [NUM_RCAS-1:0][NUM_WRITE_PORTS-1:0][RESULT_SEL_W-1:0] result_q, result_d;

    cfg_entry_t  fifo_head;
    logic        fifo_valid;
    logic        fifo_full;
    logic        fifo_pop;
    logic [FIFO_DEPTH-1:0]                fifo_entry_valid;
    logic [FIFO_DEPTH-1:0][RCA_SEL_W-1:0] fifo_entry_sel;
    rca_cfg_op_t head_op;

    taiga_fifo #(
        .DATA_WIDTH ($bits(cfg_entry_t)),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (RCA_SEL_W)
    ) u_cfg_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (cfg_valid && cfg_ready),
        .pop         (fifo_pop),
        .data_in     ({cfg, cfg_id}),
        .data_out    (fifo_head),
        .valid       (fifo_valid),
        .full        (fifo_full),
        .entry_valid (fifo_entry_valid),
        .entry_tags  (fifo_entry_sel)
    );

    assign cfg_ready      = !fifo_full;
    assign head_op        = classify_cfg(fifo_head.pkt);
    assign done_valid     = (state_q == DONE);
    assign done_id        = done_id_q;
    assign done_err       = done_err_q;
    assign rca_cfg        = regs_q;
    assign grid_mux_sel   = grid_q;
    assign io_mux_sel     = io_q;
    assign result_mux_sel = result_q;

    // An RCA has pending config while any buffered packet targets it.
    always_comb begin
        cfg_pending = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            for (int unsigned r = 0; r < NUM_RCAS; r++) begin
                if (fifo_entry_valid[i] && (fifo_entry_sel[i] == RCA_SEL_W'(r))) begin
                    cfg_pending[r] = 1'b1;
                end
            end
        end
    end

    // Apply/complete FSM: head packet is written and popped on the same edge.
    always_comb begin
        state_d    = state_q;
        done_id_d  = done_id_q;
        done_err_d = done_err_q;
        fifo_pop   = 1'b0;
        regs_d     = regs_q;
        grid_d     = grid_q;
        io_d       = io_q;
        result_d   = result_q;
        case (state_q)
            IDLE: begin
                if (fifo_valid) begin
                    if (head_op == CFG_INVALID) begin
                        fifo_pop   = 1'b1;
                        done_id_d  = fifo_head.id;
                        done_err_d = 1'b1;
                        state_d    = DONE;
                    end else if (!rca_busy[fifo_head.pkt.rca_sel]) begin
                        fifo_pop   = 1'b1;
                        done_id_d  = fifo_head.id;
                        done_err_d = 1'b0;
                        state_d    = DONE;
                        case (head_op)
                            CFG_CPU_REG: begin
                                if (fifo_head.pkt.rca_cpu_src_dest) begin
                                    regs_d[fifo_head.pkt.rca_sel].dest[fifo_head.pkt.rca_cpu_port_sel[WR_IDX_W-1:0]] =
                                        fifo_head.pkt.rca_cpu_reg_addr;
                                end else begin
                                    regs_d[fifo_head.pkt.rca_sel].src[fifo_head.pkt.rca_cpu_port_sel] =
                                        fifo_head.pkt.rca_cpu_reg_addr;
                                end
                            end
                            CFG_GRID_MUX: begin
                                grid_d[fifo_head.pkt.rca_sel][fifo_head.pkt.grid_mux_addr[GRID_ADDR_W-2:0]] =
                                    fifo_head.pkt.grid_mux_sel;
                            end
                            CFG_IO_MUX: begin
                                io_d[fifo_head.pkt.rca_sel][fifo_head.pkt.io_mux_addr[IO_ADDR_W-2:0]] =
                                    fifo_head.pkt.io_mux_sel;
                            end
                            CFG_RESULT_MUX: begin
                                result_d[fifo_head.pkt.rca_sel][fifo_head.pkt.rca_result_mux_addr[RESULT_ADDR_W-2:0]] =
                                    fifo_head.pkt.rca_result_mux_sel;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, completion record and config tables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            done_id_q  <= '0;
            done_err_q <= 1'b0;
            regs_q     <= '0;
            grid_q     <= '0;
            io_q       <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            done_id_q  <= done_id_d;
            done_err_q <= done_err_d;
            regs_q     <= regs_d;
            grid_q     <= grid_d;
            io_q       <= io_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: tb/tb_rca_config_unit.sv
// Scoreboard bench for rca_config_unit.
module tb_rca_config_unit;
    import rca_config_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic cfg_valid;
    logic cfg_ready;
    rca_inputs_t cfg;
    id_t cfg_id;
    logic [NUM_RCAS-1:0] rca_busy;
    logic [NUM_RCAS-1:0] cfg_pending;
    logic done_valid;
    id_t done_id;
    logic done_err;
    rca_cfg_regs_t [NUM_RCAS-1:0] rca_cfg;
    logic [NUM_RCAS*NUM_GRID_MUXES*GRID_SEL_W-1:0]    grid_mux_sel;
    logic [NUM_RCAS*GRID_NUM_ROWS*IO_SEL_W-1:0]       io_mux_sel;
    logic [NUM_RCAS*NUM_WRITE_PORTS*RESULT_SEL_W-1:0] result_mux_sel;

    always #5 clk = ~clk;

    rca_config_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg            (cfg),
        .cfg_id         (cfg_id),
        .rca_busy       (rca_busy),
        .cfg_pending    (cfg_pending),
        .done_valid     (done_valid),
        .done_id        (done_id),
        .done_err       (done_err),
        .rca_cfg        (rca_cfg),
        .grid_mux_sel   (grid_mux_sel),
        .io_mux_sel     (io_mux_sel),
        .result_mux_sel (result_mux_sel)
    );

    typedef struct packed {
        id_t  id;
        logic err;
    } done_rec_t;

    done_rec_t exp_q[$];
    done_rec_t obs_q[$];

    rca_cfg_regs_t [NUM_RCAS-1:0] m_regs;
    logic [NUM_RCAS-1:0][NUM_GRID_MUXES-1:0][GRID_SEL_W-1:0]    m_grid;
    logic [NUM_RCAS-1:0][GRID_NUM_ROWS-1:0][IO_SEL_W-1:0]       m_io;
    logic [NUM_RCAS-1:0][NUM_WRITE_PORTS-1:0][RESULT_SEL_W-1:0] m_res;

    int tests_run = 0;
    int fails = 0;

    // Done monitor: records every completion pulse, sampled after the edge.
    always @(posedge clk) begin
        #2;
        if (done_valid === 1'b1) obs_q.push_back({done_id, done_err});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests_run, fails);
        $fatal(1, "watchdog");
    end

    function automatic rca_inputs_t mk_cpu(input logic [RCA_SEL_W-1:0] rca, input logic dest,
                                           input logic [PORT_SEL_W-1:0] port, input logic [REG_ADDR_W-1:0] addr);
        rca_inputs_t p = '0;
        p.rca_sel = rca; p.rca_cpu_reg_config = 1'b1;
        p.rca_cpu_src_dest = dest; p.rca_cpu_port_sel = port; p.rca_cpu_reg_addr = addr;
        return p;
    endfunction

    function automatic rca_inputs_t mk_grid(input logic [RCA_SEL_W-1:0] rca, input logic [GRID_ADDR_W-1:0] addr,
                                            input logic [GRID_SEL_W-1:0] sel);
        rca_inputs_t p = '0;
        p.rca_sel = rca; p.rca_grid_mux_config = 1'b1; p.grid_mux_addr = addr; p.grid_mux_sel = sel;
        return p;
    endfunction

    function automatic rca_inputs_t mk_io(input logic [RCA_SEL_W-1:0] rca, input logic [IO_ADDR_W-1:0] row,
                                          input logic [IO_SEL_W-1:0] sel);
        rca_inputs_t p = '0;
        p.rca_sel = rca; p.rca_io_mux_config = 1'b1; p.io_mux_addr = row; p.io_mux_sel = sel;
        return p;
    endfunction

    function automatic rca_inputs_t mk_res(input logic [RCA_SEL_W-1:0] rca, input logic [RESULT_ADDR_W-1:0] port,
                                           input logic [RESULT_SEL_W-1:0] sel);
        rca_inputs_t p = '0;
        p.rca_sel = rca; p.rca_result_mux_config = 1'b1; p.rca_result_mux_addr = port; p.rca_result_mux_sel = sel;
        return p;
    endfunction

    // Model update for a packet the bench knows to be well-formed.
    task automatic model_apply(input rca_inputs_t p);
        if (p.rca_cpu_reg_config) begin
            if (p.rca_cpu_src_dest) m_regs[p.rca_sel].dest[p.rca_cpu_port_sel[0]] = p.rca_cpu_reg_addr;
            else                    m_regs[p.rca_sel].src[p.rca_cpu_port_sel]   = p.rca_cpu_reg_addr;
        end else if (p.rca_grid_mux_config) begin
            m_grid[p.rca_sel][p.grid_mux_addr[4:0]] = p.grid_mux_sel;
        end else if (p.rca_io_mux_config) begin
            m_io[p.rca_sel][p.io_mux_addr[1:0]] = p.io_mux_sel;
        end else if (p.rca_result_mux_config) begin
            m_res[p.rca_sel][p.rca_result_mux_addr[0]] = p.rca_result_mux_sel;
        end
    endtask

    task automatic model_clear();
        m_regs = '0; m_grid = '0; m_io = '0; m_res = '0;
    endtask

    // Offer one packet starting at a negedge; returns at the negedge after acceptance.
    task automatic send(input rca_inputs_t p, input id_t id, input logic exp_err);
        cfg_valid = 1'b1; cfg = p; cfg_id = id;
        for (int i = 0; i < 50 && cfg_ready !== 1'b1; i++) @(negedge clk);
        if (cfg_ready !== 1'b1) begin
            tests_run++; fails++;
            $display("FAIL send_timeout: id=%0d cfg_ready=%b required 1", id, cfg_ready);
        end else begin
            exp_q.push_back({id, exp_err});
            if (!exp_err) model_apply(p);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Bounded wait until n completions have been observed.
    task automatic wait_obs(input int n);
        for (int i = 0; i < 60 && obs_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; cfg = '0; cfg_id = '0; rca_busy = '0;
        model_clear();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({done_valid, done_err, done_id, cfg_pending, cfg_ready} !== {1'b0, 1'b0, 3'd0, 3'b000, 1'b1}) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b err=%b id=%0d pend=%b ready=%b, required 0 0 0 000 1",
                     done_valid, done_err, done_id, cfg_pending, cfg_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({rca_cfg, grid_mux_sel, io_mux_sel, result_mux_sel} !== '0) begin
            fails++; $display("FAIL reset_tables: tables not all zero after reset");
        end
        tests_run++;
        if (done_valid !== 1'b0 || cfg_ready !== 1'b1) begin
            fails++; $display("FAIL reset_release: valid=%b ready=%b required 0 1", done_valid, cfg_ready);
        end
    endtask

    task automatic test_cpu_reg_latency();
        done_rec_t e, o;
        send(mk_cpu(2'd1, 1'b0, 3'd3, 5'd17), 3'd5, 1'b0);
        tests_run++;
        if (cfg_pending !== 3'b010) begin
            fails++; $display("FAIL t1_pending: got %b required 010", cfg_pending);
        end
        @(negedge clk);
        tests_run++;
        if (rca_cfg[1].src[3] !== 5'd17) begin
            fails++; $display("FAIL t1_src: got %0d required 17", rca_cfg[1].src[3]);
        end
        tests_run++;
        if ({done_valid, done_id, done_err} !== {1'b1, 3'd5, 1'b0}) begin
            fails++; $display("FAIL t1_done: got valid=%b id=%0d err=%b required 1 5 0", done_valid, done_id, done_err);
        end
        @(negedge clk);
        tests_run++;
        if (done_valid !== 1'b0 || cfg_pending !== 3'b000) begin
            fails++; $display("FAIL t1_pulse: valid=%b pend=%b required 0 000", done_valid, cfg_pending);
        end
        e = exp_q.pop_front();
        tests_run++;
        if (obs_q.size() != 1) begin
            fails++; $display("FAIL t1_sb_count: got %0d completions required 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin fails++; $display("FAIL t1_sb: got id=%0d err=%b required id=%0d err=%b", o.id, o.err, e.id, e.err); end
        end
        tests_run++;
        if (rca_cfg !== m_regs) begin fails++; $display("FAIL t1_regs: got %h required %h", rca_cfg, m_regs); end
        obs_q.delete();
    endtask

    task automatic test_busy_hold();
        done_rec_t e, o;
        rca_busy = 3'b100;
        send(mk_grid(2'd2, 6'd31, 3'd6), 3'd1, 1'b0);
        repeat (4) @(negedge clk);
        tests_run++;
        if (obs_q.size() != 0 || cfg_pending !== 3'b100 || grid_mux_sel[287:285] !== 3'd0) begin
            fails++;
            $display("FAIL t2_held: dones=%0d pend=%b sel=%0d required 0 100 0", obs_q.size(), cfg_pending, grid_mux_sel[287:285]);
        end
        rca_busy = 3'b000;
        wait_obs(1);
        e = exp_q.pop_front();
        tests_run++;
        if (obs_q.size() == 0) begin
            fails++; $display("FAIL t2_done: got no completion required id=%0d", e.id);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin fails++; $display("FAIL t2_done: got id=%0d err=%b required id=%0d err=%b", o.id, o.err, e.id, e.err); end
        end
        tests_run++;
        if (cfg_pending !== 3'b000 || grid_mux_sel[287:285] !== 3'd6 || grid_mux_sel !== m_grid) begin
            fails++; $display("FAIL t2_applied: pend=%b sel=%0d required 000 6", cfg_pending, grid_mux_sel[287:285]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        done_rec_t e, o;
        rca_busy = 3'b001;
        send(mk_cpu(2'd0, 1'b1, 3'd0, 5'd9), 3'd2, 1'b0);
        send(mk_cpu(2'd0, 1'b1, 3'd1, 5'd10), 3'd3, 1'b0);
        cfg_valid = 1'b1; cfg = mk_cpu(2'd0, 1'b0, 3'd4, 5'd11); cfg_id = 3'd4;
        repeat (3) begin
            tests_run++;
            if (cfg_ready !== 1'b0) begin fails++; $display("FAIL t3_full: cfg_ready=%b required 0", cfg_ready); end
            @(negedge clk);
        end
        tests_run++;
        if (obs_q.size() != 0) begin fails++; $display("FAIL t3_early_done: got %0d completions required 0", obs_q.size()); end
        rca_busy = 3'b000;
        for (int i = 0; i < 20 && cfg_ready !== 1'b1; i++) @(negedge clk);
        tests_run++;
        if (cfg_ready !== 1'b1) begin
            fails++; $display("FAIL t3_ready: cfg_ready=%b required 1", cfg_ready);
        end else begin
            exp_q.push_back({3'd4, 1'b0});
            model_apply(cfg);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_obs(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL t3_order: missing completion, required id=%0d", e.id);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL t3_order: got id=%0d err=%b required id=%0d err=%b", o.id, o.err, e.id, e.err); end
            end
        end
        tests_run++;
        if (rca_cfg !== m_regs) begin fails++; $display("FAIL t3_regs: got %h required %h", rca_cfg, m_regs); end
        @(negedge clk);
    endtask

    task automatic test_malformed();
        done_rec_t e, o;
        rca_inputs_t p;
        rca_busy = 3'b111;
        p = mk_cpu(2'd0, 1'b0, 3'd1, 5'd7);
        p.rca_grid_mux_config = 1'b1;
        send(p, 3'd6, 1'b1);
        send(mk_grid(2'd3, 6'd0, 3'd5), 3'd7, 1'b1);
        send(mk_cpu(2'd1, 1'b1, 3'd2, 5'd8), 3'd0, 1'b1);
        wait_obs(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL t4_err: missing completion, required id=%0d err=1", e.id);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL t4_err: got id=%0d err=%b required id=%0d err=%b", o.id, o.err, e.id, e.err); end
            end
        end
        tests_run++;
        if (rca_cfg !== m_regs || grid_mux_sel !== m_grid || io_mux_sel !== m_io || result_mux_sel !== m_res) begin
            fails++; $display("FAIL t4_tables: tables changed by malformed packet");
        end
        rca_busy = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        rca_busy = 3'b010;
        send(mk_cpu(2'd1, 1'b0, 3'd0, 5'd21), 3'd1, 1'b0);
        send(mk_grid(2'd1, 6'd5, 3'd3), 3'd2, 1'b0);
        tests_run++;
        if (cfg_pending !== 3'b010 || cfg_ready !== 1'b0) begin
            fails++; $display("FAIL t5_queued: pend=%b ready=%b required 010 0", cfg_pending, cfg_ready);
        end
        rca_busy = 3'b000;
        @(negedge clk);
        tests_run++;
        if (done_valid !== 1'b1) begin fails++; $display("FAIL t5_in_done: done_valid=%b required 1", done_valid); end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({done_valid, cfg_pending, cfg_ready} !== {1'b0, 3'b000, 1'b1}) begin
            fails++; $display("FAIL t5_async: valid=%b pend=%b ready=%b required 0 000 1", done_valid, cfg_pending, cfg_ready);
        end
        tests_run++;
        if ({rca_cfg, grid_mux_sel, io_mux_sel, result_mux_sel} !== '0) begin
            fails++; $display("FAIL t5_tables: tables not cleared by async reset");
        end
        exp_q.delete(); obs_q.delete(); model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        tests_run++;
        if (obs_q.size() != 0 || cfg_pending !== 3'b000) begin
            fails++; $display("FAIL t5_stale: dones=%0d pend=%b required 0 000", obs_q.size(), cfg_pending);
        end
        tests_run++;
        if ({rca_cfg, grid_mux_sel} !== '0) begin fails++; $display("FAIL t5_post: tables changed after reset release"); end
    endtask

    task automatic test_io_result();
        done_rec_t e, o;
        send(mk_io(2'd0, 3'd3, 2'd2), 3'd3, 1'b0);
        send(mk_res(2'd0, 2'd1, 2'd3), 3'd4, 1'b0);
        wait_obs(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL t6_done: missing completion, required id=%0d", e.id);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL t6_done: got id=%0d err=%b required id=%0d err=%b", o.id, o.err, e.id, e.err); end
            end
        end
        tests_run++;
        if (io_mux_sel[7:6] !== 2'd2 || result_mux_sel[3:2] !== 2'd3) begin
            fails++; $display("FAIL t6_fields: io=%0d res=%0d required 2 3", io_mux_sel[7:6], result_mux_sel[3:2]);
        end
        tests_run++;
        if (io_mux_sel !== m_io || result_mux_sel !== m_res || grid_mux_sel !== '0 || rca_cfg !== '0) begin
            fails++; $display("FAIL t6_others: io=%h res=%h required io=%h res=%h, grid/regs zero", io_mux_sel, result_mux_sel, m_io, m_res);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_reg_latency();
        test_busy_hold();
        test_back_to_back();
        test_malformed();
        test_reset_mid_op();
        test_io_result();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
